// File: rtl/id_ex_reg.sv
// Decode-to-execute pipeline register with NZCV flag storage, bubble
// insertion on stall/flush/taken-branch, and a saturating bubble counter.
module id_ex_reg #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned REGW  = 4,
  parameter int unsigned CNTW  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_e,
  input  logic             flush_e,
  input  logic             branch_taken,
  input  logic             valid_d,
  input  logic             pc_src_d,
  input  logic             reg_write_d,
  input  logic             mem_write_d,
  input  logic             mem_to_reg_d,
  input  logic             no_write_d,
  input  logic             branch_d,
  input  logic             flag_write_d,
  input  logic             alu_src_d,
  input  logic [2:0]       cond_d,
  input  logic [2:0]       alu_control_d,
  input  logic [WIDTH-1:0] rd1_d,
  input  logic [WIDTH-1:0] rd2_d,
  input  logic [WIDTH-1:0] ext_imm_d,
  input  logic [REGW-1:0]  wa3_d,
  input  logic [REGW-1:0]  ra1_d,
  input  logic [REGW-1:0]  ra2_d,
  input  logic             flag_write_p,
  input  logic [3:0]       alu_flags,
  output logic             valid_e,
  output logic             pc_src_e,
  output logic             reg_write_e,
  output logic             mem_write_e,
  output logic             mem_to_reg_e,
  output logic             no_write_e,
  output logic             branch_e,
  output logic             flag_write_e,
  output logic             alu_src_e,
  output logic [2:0]       cond_e,
  output logic [2:0]       alu_control_e,
  output logic [WIDTH-1:0] rd1_e,
  output logic [WIDTH-1:0] rd2_e,
  output logic [WIDTH-1:0] ext_imm_e,
  output logic [REGW-1:0]  wa3_e,
  output logic [REGW-1:0]  ra1_e,
  output logic [REGW-1:0]  ra2_e,
  output logic [3:0]       flags_e,
  output logic [CNTW-1:0]  bubble_count
);

  localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

  // Flush wins over stall: a bubble squashes whatever was held.
  logic bubble;
  assign bubble = flush_e | branch_taken;

  // E register: clear on reset or bubble, hold on stall, else load from D.
  always_ff @(posedge clk) begin
    if (!reset || bubble) begin
      valid_e       <= 1'b0;
      pc_src_e      <= 1'b0;
      reg_write_e   <= 1'b0;
      mem_write_e   <= 1'b0;
      mem_to_reg_e  <= 1'b0;
      no_write_e    <= 1'b0;
      branch_e      <= 1'b0;
      flag_write_e  <= 1'b0;
      alu_src_e     <= 1'b0;
      cond_e        <= 3'b000;
      alu_control_e <= 3'b000;
      rd1_e         <= '0;
      rd2_e         <= '0;
      ext_imm_e     <= '0;
      wa3_e         <= '0;
      ra1_e         <= '0;
      ra2_e         <= '0;
    end else if (!stall_e) begin
      valid_e       <= valid_d;
      pc_src_e      <= pc_src_d;
      reg_write_e   <= reg_write_d;
      mem_write_e   <= mem_write_d;
      mem_to_reg_e  <= mem_to_reg_d;
      no_write_e    <= no_write_d;
      branch_e      <= branch_d;
      flag_write_e  <= flag_write_d;
      alu_src_e     <= alu_src_d;
      cond_e        <= cond_d;
      alu_control_e <= alu_control_d;
      rd1_e         <= rd1_d;
      rd2_e         <= rd2_d;
      ext_imm_e     <= ext_imm_d;
      wa3_e         <= wa3_d;
      ra1_e         <= ra1_d;
      ra2_e         <= ra2_d;
    end
  end

  // Flags: the instruction in E still retires its flag write during a flush;
  // stall gating avoids a second update while that instruction is re-evaluated.
  always_ff @(posedge clk) begin
    if (!reset) begin
      flags_e <= 4'b0000;
    end else if (flag_write_p && !stall_e) begin
      flags_e <= alu_flags;
    end
  end

  // Saturating count of inserted bubbles.
  always_ff @(posedge clk) begin
    if (!reset) begin
      bubble_count <= '0;
    end else if (bubble && (bubble_count != CNT_MAX)) begin
      bubble_count <= bubble_count + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed self-checking bench for id_ex_reg; a second instance with a
// 4-bit counter shares all inputs to exercise saturation.
module tb_id_ex_reg;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned REGW  = 4;

  logic clk = 1'b0;
  logic reset;
  logic stall_e, flush_e, branch_taken, valid_d;
  logic pc_src_d, reg_write_d, mem_write_d, mem_to_reg_d, no_write_d;
  logic branch_d, flag_write_d, alu_src_d;
  logic [2:0] cond_d, alu_control_d;
  logic [WIDTH-1:0] rd1_d, rd2_d, ext_imm_d;
  logic [REGW-1:0] wa3_d, ra1_d, ra2_d;
  logic flag_write_p;
  logic [3:0] alu_flags;

  logic valid_e, pc_src_e, reg_write_e, mem_write_e, mem_to_reg_e, no_write_e;
  logic branch_e, flag_write_e, alu_src_e;
  logic [2:0] cond_e, alu_control_e;
  logic [WIDTH-1:0] rd1_e, rd2_e, ext_imm_e;
  logic [REGW-1:0] wa3_e, ra1_e, ra2_e;
  logic [3:0] flags_e;
  logic [15:0] bubble_count;

  logic valid_s, pc_src_s, reg_write_s, mem_write_s, mem_to_reg_s, no_write_s;
  logic branch_s, flag_write_s, alu_src_s;
  logic [2:0] cond_s, alu_control_s;
  logic [WIDTH-1:0] rd1_s, rd2_s, ext_imm_s;
  logic [REGW-1:0] wa3_s, ra1_s, ra2_s;
  logic [3:0] flags_s;
  logic [3:0] bubble_count_s;

  logic [122:0] e_all, e_all_s;
  assign e_all = {valid_e, pc_src_e, reg_write_e, mem_write_e, mem_to_reg_e,
                  no_write_e, branch_e, flag_write_e, alu_src_e, cond_e,
                  alu_control_e, rd1_e, rd2_e, ext_imm_e, wa3_e, ra1_e, ra2_e};
  assign e_all_s = {valid_s, pc_src_s, reg_write_s, mem_write_s, mem_to_reg_s,
                    no_write_s, branch_s, flag_write_s, alu_src_s, cond_s,
                    alu_control_s, rd1_s, rd2_s, ext_imm_s, wa3_s, ra1_s, ra2_s};

  int total = 0;
  int bad = 0;
  logic [15:0] exp_cnt;
  logic [3:0]  exp_cnt_s;

  always #5 clk = ~clk;

  id_ex_reg #(.WIDTH(WIDTH), .REGW(REGW), .CNTW(16)) dut (
    .clk(clk), .reset(reset), .stall_e(stall_e), .flush_e(flush_e),
    .branch_taken(branch_taken), .valid_d(valid_d), .pc_src_d(pc_src_d),
    .reg_write_d(reg_write_d), .mem_write_d(mem_write_d),
    .mem_to_reg_d(mem_to_reg_d), .no_write_d(no_write_d), .branch_d(branch_d),
    .flag_write_d(flag_write_d), .alu_src_d(alu_src_d), .cond_d(cond_d),
    .alu_control_d(alu_control_d), .rd1_d(rd1_d), .rd2_d(rd2_d),
    .ext_imm_d(ext_imm_d), .wa3_d(wa3_d), .ra1_d(ra1_d), .ra2_d(ra2_d),
    .flag_write_p(flag_write_p), .alu_flags(alu_flags),
    .valid_e(valid_e), .pc_src_e(pc_src_e), .reg_write_e(reg_write_e),
    .mem_write_e(mem_write_e), .mem_to_reg_e(mem_to_reg_e),
    .no_write_e(no_write_e), .branch_e(branch_e), .flag_write_e(flag_write_e),
    .alu_src_e(alu_src_e), .cond_e(cond_e), .alu_control_e(alu_control_e),
    .rd1_e(rd1_e), .rd2_e(rd2_e), .ext_imm_e(ext_imm_e), .wa3_e(wa3_e),
    .ra1_e(ra1_e), .ra2_e(ra2_e), .flags_e(flags_e),
    .bubble_count(bubble_count)
  );

  id_ex_reg #(.WIDTH(WIDTH), .REGW(REGW), .CNTW(4)) dut_s (
    .clk(clk), .reset(reset), .stall_e(stall_e), .flush_e(flush_e),
    .branch_taken(branch_taken), .valid_d(valid_d), .pc_src_d(pc_src_d),
    .reg_write_d(reg_write_d), .mem_write_d(mem_write_d),
    .mem_to_reg_d(mem_to_reg_d), .no_write_d(no_write_d), .branch_d(branch_d),
    .flag_write_d(flag_write_d), .alu_src_d(alu_src_d), .cond_d(cond_d),
    .alu_control_d(alu_control_d), .rd1_d(rd1_d), .rd2_d(rd2_d),
    .ext_imm_d(ext_imm_d), .wa3_d(wa3_d), .ra1_d(ra1_d), .ra2_d(ra2_d),
    .flag_write_p(flag_write_p), .alu_flags(alu_flags),
    .valid_e(valid_s), .pc_src_e(pc_src_s), .reg_write_e(reg_write_s),
    .mem_write_e(mem_write_s), .mem_to_reg_e(mem_to_reg_s),
    .no_write_e(no_write_s), .branch_e(branch_s), .flag_write_e(flag_write_s),
    .alu_src_e(alu_src_s), .cond_e(cond_s), .alu_control_e(alu_control_s),
    .rd1_e(rd1_s), .rd2_e(rd2_s), .ext_imm_e(ext_imm_s), .wa3_e(wa3_s),
    .ra1_e(ra1_s), .ra2_e(ra2_s), .flags_e(flags_s),
    .bubble_count(bubble_count_s)
  );

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_d();
    {valid_d, pc_src_d, reg_write_d, mem_write_d, mem_to_reg_d, no_write_d,
     branch_d, flag_write_d, alu_src_d} = '0;
    cond_d = '0; alu_control_d = '0;
    rd1_d = '0; rd2_d = '0; ext_imm_d = '0;
    wa3_d = '0; ra1_d = '0; ra2_d = '0;
    stall_e = 1'b0; flush_e = 1'b0; branch_taken = 1'b0;
    flag_write_p = 1'b0; alu_flags = '0;
  endtask

  task automatic random_d();
    {valid_d, pc_src_d, reg_write_d, mem_write_d, mem_to_reg_d, no_write_d,
     branch_d, flag_write_d, alu_src_d} = 9'($urandom);
    cond_d = 3'($urandom); alu_control_d = 3'($urandom);
    rd1_d = $urandom; rd2_d = $urandom; ext_imm_d = $urandom;
    wa3_d = 4'($urandom); ra1_d = 4'($urandom); ra2_d = 4'($urandom);
    {stall_e, flush_e, branch_taken, flag_write_p} = 4'($urandom);
    alu_flags = 4'($urandom);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      random_d();
      tick();
    end
    total++; if (e_all !== '0) begin bad++; $display("FAIL reset_e_all got=%h want=0", e_all); end
    total++; if (e_all_s !== '0) begin bad++; $display("FAIL reset_e_all_s got=%h want=0", e_all_s); end
    total++; if (flags_e !== 4'b0000) begin bad++; $display("FAIL reset_flags got=%b want=0000", flags_e); end
    total++; if (bubble_count !== 16'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", bubble_count); end
    total++; if (bubble_count_s !== 4'd0) begin bad++; $display("FAIL reset_count_s got=%0d want=0", bubble_count_s); end
    exp_cnt = '0; exp_cnt_s = '0;
    clear_d();
    reset = 1'b1;
    valid_d = 1'b1; rd1_d = 32'hCAFE_0001; ra2_d = 4'h7;
    tick();
    total++; if (valid_e !== 1'b1) begin bad++; $display("FAIL release_valid got=%b want=1", valid_e); end
    total++; if (rd1_e !== 32'hCAFE_0001) begin bad++; $display("FAIL release_rd1 got=%h want=cafe0001", rd1_e); end
    total++; if (ra2_e !== 4'h7) begin bad++; $display("FAIL release_ra2 got=%h want=7", ra2_e); end
  endtask

  task automatic test_pass_through();
    clear_d();
    reg_write_d = 1'b1; cond_d = 3'b001; rd1_d = 32'h1234_5678;
    wa3_d = 4'hA; valid_d = 1'b1;
    tick();
    total++; if (reg_write_e !== 1'b1) begin bad++; $display("FAIL pt_reg_write got=%b want=1", reg_write_e); end
    total++; if (cond_e !== 3'b001) begin bad++; $display("FAIL pt_cond got=%b want=001", cond_e); end
    total++; if (rd1_e !== 32'h1234_5678) begin bad++; $display("FAIL pt_rd1 got=%h want=12345678", rd1_e); end
    total++; if (wa3_e !== 4'hA) begin bad++; $display("FAIL pt_wa3 got=%h want=a", wa3_e); end
    total++; if (valid_e !== 1'b1) begin bad++; $display("FAIL pt_valid got=%b want=1", valid_e); end
    total++; if (mem_write_e !== 1'b0) begin bad++; $display("FAIL pt_mem_write got=%b want=0", mem_write_e); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] imm [4] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0F0F_F0F0};
    logic [2:0]  op  [4] = '{3'd1, 3'd7, 3'd4, 3'd2};
    clear_d();
    for (int i = 0; i < 4; i++) begin
      ext_imm_d = imm[i]; alu_control_d = op[i]; ra1_d = 4'(i + 3);
      tick();
      total++; if (ext_imm_e !== imm[i]) begin bad++; $display("FAIL b2b_imm[%0d] got=%h want=%h", i, ext_imm_e, imm[i]); end
      total++; if (alu_control_e !== op[i]) begin bad++; $display("FAIL b2b_aluctl[%0d] got=%0d want=%0d", i, alu_control_e, op[i]); end
      total++; if (ra1_e !== 4'(i + 3)) begin bad++; $display("FAIL b2b_ra1[%0d] got=%0d want=%0d", i, ra1_e, i + 3); end
    end
  endtask

  task automatic test_stall_flush();
    clear_d();
    rd2_d = 32'hDEAD_BEEF; valid_d = 1'b1; reg_write_d = 1'b1;
    tick();
    total++; if (rd2_e !== 32'hDEAD_BEEF) begin bad++; $display("FAIL sf_load got=%h want=deadbeef", rd2_e); end
    stall_e = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rd2_d = $urandom; valid_d = 1'b0;
      tick();
      total++; if (rd2_e !== 32'hDEAD_BEEF) begin bad++; $display("FAIL sf_hold[%0d] got=%h want=deadbeef", i, rd2_e); end
    end
    total++; if (valid_e !== 1'b1) begin bad++; $display("FAIL sf_hold_valid got=%b want=1", valid_e); end
    flush_e = 1'b1; valid_d = 1'b1;
    tick();
    exp_cnt++; exp_cnt_s++;
    total++; if (e_all !== '0) begin bad++; $display("FAIL sf_bubble got=%h want=0", e_all); end
    total++; if (bubble_count !== exp_cnt) begin bad++; $display("FAIL sf_count got=%0d want=%0d", bubble_count, exp_cnt); end
  endtask

  task automatic test_branch_flags();
    clear_d();
    valid_d = 1'b1; reg_write_d = 1'b1; mem_write_d = 1'b1; rd1_d = 32'h5555_AAAA;
    tick();
    branch_taken = 1'b1; flag_write_p = 1'b1; alu_flags = 4'b0100;
    tick();
    exp_cnt++; exp_cnt_s++;
    total++; if (e_all !== '0) begin bad++; $display("FAIL br_bubble got=%h want=0", e_all); end
    total++; if (flags_e !== 4'b0100) begin bad++; $display("FAIL br_flags got=%b want=0100", flags_e); end
    total++; if (bubble_count !== exp_cnt) begin bad++; $display("FAIL br_count got=%0d want=%0d", bubble_count, exp_cnt); end
    branch_taken = 1'b0; stall_e = 1'b1; alu_flags = 4'b1011;
    tick();
    total++; if (flags_e !== 4'b0100) begin bad++; $display("FAIL br_stall_flags got=%b want=0100", flags_e); end
    stall_e = 1'b0;
    tick();
    total++; if (flags_e !== 4'b1011) begin bad++; $display("FAIL br_write_flags got=%b want=1011", flags_e); end
    flag_write_p = 1'b0; alu_flags = 4'b0001;
    tick();
    total++; if (flags_e !== 4'b1011) begin bad++; $display("FAIL br_hold_flags got=%b want=1011", flags_e); end
  endtask

  task automatic test_saturation();
    clear_d();
    valid_d = 1'b1; rd1_d = 32'h1;
    flush_e = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      exp_cnt++;
      if (exp_cnt_s != 4'hF) exp_cnt_s++;
      total++; if (bubble_count_s !== exp_cnt_s) begin bad++; $display("FAIL sat_count_s[%0d] got=%0d want=%0d", i, bubble_count_s, exp_cnt_s); end
    end
    total++; if (bubble_count_s !== 4'd15) begin bad++; $display("FAIL sat_final got=%0d want=15", bubble_count_s); end
    total++; if (bubble_count !== exp_cnt) begin bad++; $display("FAIL sat_wide got=%0d want=%0d", bubble_count, exp_cnt); end
    total++; if (e_all_s !== '0) begin bad++; $display("FAIL sat_bubble_s got=%h want=0", e_all_s); end
  endtask

  task automatic test_reset_mid();
    clear_d();
    valid_d = 1'b1; flag_write_p = 1'b1; alu_flags = 4'b1110;
    tick();
    flag_write_p = 1'b0; stall_e = 1'b1;
    tick();
    total++; if (valid_e !== 1'b1) begin bad++; $display("FAIL rm_pre_valid got=%b want=1", valid_e); end
    total++; if (flags_e !== 4'b1110) begin bad++; $display("FAIL rm_pre_flags got=%b want=1110", flags_e); end
    reset = 1'b0;
    tick();
    total++; if (valid_e !== 1'b0) begin bad++; $display("FAIL rm_valid got=%b want=0", valid_e); end
    total++; if (flags_e !== 4'b0000) begin bad++; $display("FAIL rm_flags got=%b want=0000", flags_e); end
    total++; if (bubble_count !== 16'd0) begin bad++; $display("FAIL rm_count got=%0d want=0", bubble_count); end
    total++; if (e_all !== '0) begin bad++; $display("FAIL rm_e_all got=%h want=0", e_all); end
    reset = 1'b1;
  endtask

  initial begin
    clear_d();
    reset = 1'b0;
    exp_cnt = '0; exp_cnt_s = '0;
    #1;
    test_reset();
    test_pass_through();
    test_back_to_back();
    test_stall_flush();
    test_branch_flags();
    test_saturation();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
